// File: rtl/cache_controller_pkg.sv
// Shared cache geometry and controller state type for the direct-mapped cache slice.
// Word addresses split as {tag, index, offset}.
package CacheParams;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int LINE_SIZE   = 4;
  localparam int NUM_LINES   = 16;
  localparam int OFFSET_BITS = $clog2(LINE_SIZE);
  localparam int IDX_BITS    = $clog2(NUM_LINES);
  localparam int TAG_BITS    = ADDR_WIDTH - IDX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    WB,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } cache_ctrl_state_t;

endpackage

// File: rtl/cache_controller.sv
// Sequencing FSM for a clockless direct-mapped write-back cache: valid sweep, lookup, victim write-back, line fill.
// Optional hit/miss/write-back counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_controller
  import CacheParams::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqVal,
  output logic                  ReqRdy,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic                  ReqWrEn,
  input  logic [DATA_WIDTH-1:0] ReqWrData,
  output logic                  RespVal,
  output logic [DATA_WIDTH-1:0] RespData,
  output logic                  CacheRst,
  output logic [ADDR_WIDTH-1:0] CacheAddr,
  output logic                  CacheAddrVal,
  output logic [DATA_WIDTH-1:0] CacheWrData,
  output logic                  CacheReplaceEn,
  output logic                  CacheWrEn,
  input  logic [DATA_WIDTH-1:0] CacheRdData,
  input  logic                  CacheHit,
  input  logic                  CacheDirty,
  input  logic [TAG_BITS-1:0]   CacheVictimTag,
  output logic                  MemReqVal,
  input  logic                  MemReqRdy,
  output logic                  MemReqWrEn,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWrData,
  input  logic                  MemRespVal,
  input  logic [DATA_WIDTH-1:0] MemRdData
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]           HitCnt,
  output logic [31:0]           MissCnt,
  output logic [31:0]           WbCnt
`endif
);

  cache_ctrl_state_t state, nextState;

  logic [IDX_BITS-1:0]    idxCnt;
  logic [OFFSET_BITS-1:0] beat;
  logic [ADDR_WIDTH-1:0]  reqAddr;
  logic                   reqWrEn;
  logic [DATA_WIDTH-1:0]  reqWrData;
  logic [TAG_BITS-1:0]    victimTag;
  logic [DATA_WIDTH-1:0]  respData;
  logic                   replay;

  logic [TAG_BITS-1:0]    reqTag;
  logic [IDX_BITS-1:0]    reqIdx;
  logic [ADDR_WIDTH-1:0]  lineBeatAddr;
  logic                   lastBeat;

  assign reqTag       = reqAddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign reqIdx       = reqAddr[OFFSET_BITS +: IDX_BITS];
  assign lineBeatAddr = {reqTag, reqIdx, beat};
  assign lastBeat     = (beat == OFFSET_BITS'(LINE_SIZE - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= INIT;
      idxCnt    <= '0;
      beat      <= '0;
      reqAddr   <= '0;
      reqWrEn   <= 1'b0;
      reqWrData <= '0;
      victimTag <= '0;
      respData  <= '0;
      replay    <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        INIT: idxCnt <= idxCnt + 1'b1;
        IDLE: begin
          if (ReqVal) begin
            reqAddr   <= ReqAddr;
            reqWrEn   <= ReqWrEn;
            reqWrData <= ReqWrData;
            replay    <= 1'b0;
          end
        end
        LOOKUP: begin
          beat <= '0;
          if (CacheHit) begin
            respData <= reqWrEn ? '0 : CacheRdData;
          end else if (CacheDirty) begin
            victimTag <= CacheVictimTag;
          end
        end
        // Beat wraps to zero after the last word, ready for the next phase.
        WB: if (MemReqRdy) beat <= beat + 1'b1;
        FILL_WAIT: begin
          if (MemRespVal) begin
            beat <= beat + 1'b1;
            if (lastBeat) replay <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState      = state;
    ReqRdy         = 1'b0;
    RespVal        = 1'b0;
    RespData       = respData;
    CacheRst       = 1'b0;
    CacheAddr      = '0;
    CacheAddrVal   = 1'b0;
    CacheWrData    = '0;
    CacheReplaceEn = 1'b0;
    CacheWrEn      = 1'b0;
    MemReqVal      = 1'b0;
    MemReqWrEn     = 1'b0;
    MemAddr        = '0;
    MemWrData      = '0;
    case (state)
      INIT: begin
        CacheRst  = 1'b1;
        CacheAddr = {{TAG_BITS{1'b0}}, idxCnt, {OFFSET_BITS{1'b0}}};
        if (idxCnt == IDX_BITS'(NUM_LINES - 1)) nextState = IDLE;
      end
      IDLE: begin
        ReqRdy = 1'b1;
        if (ReqVal) nextState = LOOKUP;
      end
      LOOKUP: begin
        CacheAddr    = reqAddr;
        CacheAddrVal = 1'b1;
        if (CacheHit) begin
          CacheWrEn   = reqWrEn;
          CacheWrData = reqWrEn ? reqWrData : '0;
          nextState   = RESP;
        end else if (CacheDirty) begin
          nextState = WB;
        end else begin
          nextState = FILL_REQ;
        end
      end
      // Cache is read with AddrVal low so the victim line's tag/valid stay untouched.
      WB: begin
        CacheAddr  = lineBeatAddr;
        MemReqVal  = 1'b1;
        MemReqWrEn = 1'b1;
        MemAddr    = {victimTag, reqIdx, beat};
        MemWrData  = CacheRdData;
        if (MemReqRdy && lastBeat) nextState = FILL_REQ;
      end
      FILL_REQ: begin
        CacheAddr = lineBeatAddr;
        MemReqVal = 1'b1;
        MemAddr   = lineBeatAddr;
        if (MemReqRdy) nextState = FILL_WAIT;
      end
      FILL_WAIT: begin
        CacheAddr = lineBeatAddr;
        if (MemRespVal) begin
          CacheAddrVal   = 1'b1;
          CacheReplaceEn = 1'b1;
          CacheWrData    = MemRdData;
          nextState      = lastBeat ? LOOKUP : FILL_REQ;
        end
      end
      RESP: begin
        RespVal   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = INIT;
    endcase
    // Reset forces every output quiet except the cache clear.
    if (Rst) begin
      nextState      = INIT;
      ReqRdy         = 1'b0;
      RespVal        = 1'b0;
      RespData       = '0;
      CacheRst       = 1'b1;
      CacheAddr      = '0;
      CacheAddrVal   = 1'b0;
      CacheWrData    = '0;
      CacheReplaceEn = 1'b0;
      CacheWrEn      = 1'b0;
      MemReqVal      = 1'b0;
      MemReqWrEn     = 1'b0;
      MemAddr        = '0;
      MemWrData      = '0;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  // The post-fill replay lookup always hits, so it is not counted as a hit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      HitCnt  <= '0;
      MissCnt <= '0;
      WbCnt   <= '0;
    end else begin
      if (state == LOOKUP) begin
        if (CacheHit) begin
          if (!replay) HitCnt <= HitCnt + 32'd1;
        end else begin
          MissCnt <= MissCnt + 32'd1;
        end
      end
      if (state == WB && MemReqRdy && lastBeat) WbCnt <= WbCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural clockless cache array and a word memory.
// Memory reads return address + 0x60 unless the word was written back.
module tb_cache_controller;
  import CacheParams::*;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic                  ReqVal;
  logic                  ReqRdy;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic                  ReqWrEn;
  logic [DATA_WIDTH-1:0] ReqWrData;
  logic                  RespVal;
  logic [DATA_WIDTH-1:0] RespData;
  logic                  CacheRst;
  logic [ADDR_WIDTH-1:0] CacheAddr;
  logic                  CacheAddrVal;
  logic [DATA_WIDTH-1:0] CacheWrData;
  logic                  CacheReplaceEn;
  logic                  CacheWrEn;
  logic [DATA_WIDTH-1:0] CacheRdData;
  logic                  CacheHit;
  logic                  CacheDirty;
  logic [TAG_BITS-1:0]   CacheVictimTag;
  logic                  MemReqVal;
  logic                  MemReqRdy;
  logic                  MemReqWrEn;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWrData;
  logic                  MemRespVal = 1'b0;
  logic [DATA_WIDTH-1:0] MemRdData = '0;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] HitCnt, MissCnt, WbCnt;
`endif

  cache_controller dut (
    .Clk(Clk), .Rst(Rst), .ReqVal(ReqVal), .ReqRdy(ReqRdy), .ReqAddr(ReqAddr),
    .ReqWrEn(ReqWrEn), .ReqWrData(ReqWrData), .RespVal(RespVal), .RespData(RespData),
    .CacheRst(CacheRst), .CacheAddr(CacheAddr), .CacheAddrVal(CacheAddrVal),
    .CacheWrData(CacheWrData), .CacheReplaceEn(CacheReplaceEn), .CacheWrEn(CacheWrEn),
    .CacheRdData(CacheRdData), .CacheHit(CacheHit), .CacheDirty(CacheDirty),
    .CacheVictimTag(CacheVictimTag), .MemReqVal(MemReqVal), .MemReqRdy(MemReqRdy),
    .MemReqWrEn(MemReqWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRespVal(MemRespVal), .MemRdData(MemRdData)
`ifdef CACHE_CTRL_PERF_EN
    , .HitCnt(HitCnt), .MissCnt(MissCnt), .WbCnt(WbCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int checkCount = 0;
  int errorCount = 0;
  int cycle = 0;
  int respCount = 0;
  int replaceCount = 0;
  int stallCycles = 0;
  int readDelay = 0;
  logic preload = 1'b0;

  logic [ADDR_WIDTH-1:0] wrAddrQ[$];
  logic [DATA_WIDTH-1:0] wrDataQ[$];
  logic [ADDR_WIDTH-1:0] rdAddrQ[$];
  logic [DATA_WIDTH-1:0] memWr[logic [ADDR_WIDTH-1:0]];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] memRead(input logic [ADDR_WIDTH-1:0] a);
    if (memWr.exists(a)) return memWr[a];
    return a + 32'h60;
  endfunction

  // Behavioural cache array: combinational read, updates applied at the clock edge.
  logic                  cValid [NUM_LINES];
  logic                  cDirty [NUM_LINES];
  logic [TAG_BITS-1:0]   cTag   [NUM_LINES];
  logic [DATA_WIDTH-1:0] cData  [NUM_LINES][LINE_SIZE];
  logic [TAG_BITS-1:0]    aTag;
  logic [IDX_BITS-1:0]    aIdx;
  logic [OFFSET_BITS-1:0] aOff;

  assign aTag           = CacheAddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign aIdx           = CacheAddr[OFFSET_BITS +: IDX_BITS];
  assign aOff           = CacheAddr[OFFSET_BITS-1:0];
  assign CacheHit       = CacheAddrVal && cValid[aIdx] && (cTag[aIdx] == aTag);
  assign CacheDirty     = cValid[aIdx] && cDirty[aIdx];
  assign CacheVictimTag = cTag[aIdx];
  assign CacheRdData    = cData[aIdx][aOff];

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        cValid[i] <= 1'b1;
        cDirty[i] <= 1'b0;
        cTag[i]   <= TAG_BITS'(1);
        for (int j = 0; j < LINE_SIZE; j++) cData[i][j] <= '0;
      end
    end else if (CacheRst) begin
      cValid[aIdx] <= 1'b0;
      cDirty[aIdx] <= 1'b0;
    end else if (CacheAddrVal && CacheReplaceEn) begin
      cData[aIdx][aOff] <= CacheWrData;
      cTag[aIdx]        <= aTag;
      cValid[aIdx]      <= 1'b1;
      cDirty[aIdx]      <= 1'b0;
    end else if (CacheAddrVal && CacheWrEn && CacheHit) begin
      cData[aIdx][aOff] <= CacheWrData;
      cDirty[aIdx]      <= 1'b1;
    end
  end

  // Memory model with a configurable read delay, plus request logging and stall stability checks.
  logic                  pendActive = 1'b0;
  int                    pendCnt = 0;
  logic [ADDR_WIDTH-1:0] pendAddr = '0;
  logic                  stallPrev = 1'b0;
  logic [ADDR_WIDTH-1:0] stallAddr = '0;
  logic [DATA_WIDTH-1:0] stallData = '0;

  always @(posedge Clk) begin
    cycle <= cycle + 1;
    if (RespVal) respCount++;
    if (CacheAddrVal && CacheReplaceEn) replaceCount++;
    MemRespVal <= 1'b0;
    if (pendActive) begin
      if (pendCnt == 0) begin
        MemRespVal <= 1'b1;
        MemRdData  <= memRead(pendAddr);
        pendActive = 1'b0;
      end else begin
        pendCnt--;
      end
    end
    if (MemReqVal && stallPrev) begin
      checkOutput("stallAddrStable", MemAddr, stallAddr);
      checkOutput("stallDataStable", MemWrData, stallData);
    end
    stallPrev = MemReqVal && !MemReqRdy;
    if (stallPrev) begin
      stallAddr = MemAddr;
      stallData = MemWrData;
      stallCycles++;
    end
    if (MemReqVal && MemReqRdy) begin
      if (MemReqWrEn) begin
        memWr[MemAddr] = MemWrData;
        wrAddrQ.push_back(MemAddr);
        wrDataQ.push_back(MemWrData);
      end else begin
        rdAddrQ.push_back(MemAddr);
        if (readDelay == 0) begin
          MemRespVal <= 1'b1;
          MemRdData  <= memRead(MemAddr);
        end else begin
          pendActive = 1'b1;
          pendCnt    = readDelay - 1;
          pendAddr   = MemAddr;
        end
      end
    end
  end

  task automatic clearLogs();
    wrAddrQ.delete();
    wrDataQ.delete();
    rdAddrQ.delete();
    stallCycles = 0;
  endtask

  // Called just after Rst drops: counts INIT cycles and confirms the sweep.
  task automatic waitInit(input string tag);
    int n = 0;
    int vCount = 0;
    for (int i = 0; i < 100; i++) begin
      if (!CacheRst) break;
      n++;
      @(negedge Clk);
    end
    for (int i = 0; i < NUM_LINES; i++) if (cValid[i]) vCount++;
    checkOutput({tag, "InitCycles"}, n, 16);
    checkOutput({tag, "ReadyAfterInit"}, ReqRdy, 1);
    checkOutput({tag, "ValidSwept"}, vCount, 0);
  endtask

  task automatic issueRequest(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              output int acceptCycle);
    ReqAddr   = addr;
    ReqWrEn   = we;
    ReqWrData = wdata;
    ReqVal    = 1'b1;
    acceptCycle = -1;
    for (int i = 0; i < 200; i++) begin
      if (ReqRdy) begin
        acceptCycle = cycle;
        break;
      end
      @(negedge Clk);
    end
    if (acceptCycle < 0) checkOutput("acceptTimeout", 0, 1);
    @(negedge Clk);
    ReqVal = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int latency);
    int acceptCycle;
    bit got = 1'b0;
    issueRequest(addr, we, wdata, acceptCycle);
    rdata   = '0;
    latency = -1;
    for (int i = 0; i < 300; i++) begin
      if (RespVal) begin
        got = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!got) begin
      checkOutput("respTimeout", 0, 1);
    end else begin
      latency = cycle - acceptCycle;
      rdata   = RespData;
      @(negedge Clk);
      checkOutput("respPulse", RespVal, 0);
    end
  endtask

  initial begin
    logic [31:0] rdata;
    int lat;
    int resp0, repl0;
    bit found;
    logic [31:0] expWb [4];
    expWb = '{32'hA0, 32'hA1, 32'hDEAD, 32'hA3};

    Rst = 1'b1; ReqVal = 1'b0; ReqAddr = '0; ReqWrEn = 1'b0; ReqWrData = '0;
    MemReqRdy = 1'b1; preload = 1'b1;
    repeat (2) @(negedge Clk);
    preload = 1'b0;
    #1;
    checkOutput("rstCacheRst", CacheRst, 1);
    checkOutput("rstReqRdy", ReqRdy, 0);
    checkOutput("rstMemReqVal", MemReqVal, 0);
    checkOutput("rstAddrVal", CacheAddrVal, 0);
    Rst = 1'b0;
    #1;
    waitInit("boot");

    $display("[TB] Load 0x40, clean miss");
    clearLogs();
    applyStimulus(32'h40, 1'b0, '0, rdata, lat);
    checkOutput("missData", rdata, 32'hA0);
    checkOutput("missLatency", lat, 11);
    checkOutput("missReadCount", rdAddrQ.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("missFillAddr", (i < rdAddrQ.size()) ? rdAddrQ[i] : 32'hFFFF_FFFF, 32'h40 + i);
    checkOutput("missWriteCount", wrAddrQ.size(), 0);
    checkOutput("missReplaceCount", replaceCount, 4);

    $display("[TB] Load 0x41, hit");
    clearLogs();
    applyStimulus(32'h41, 1'b0, '0, rdata, lat);
    checkOutput("hitData", rdata, 32'hA1);
    checkOutput("hitLatency", lat, 2);
    checkOutput("hitMemReqs", rdAddrQ.size() + wrAddrQ.size(), 0);

    $display("[TB] Store 0xDEAD to 0x42, hit");
    clearLogs();
    applyStimulus(32'h42, 1'b1, 32'hDEAD, rdata, lat);
    checkOutput("storeData", rdata, 0);
    checkOutput("storeLatency", lat, 2);
    checkOutput("storeMemReqs", rdAddrQ.size() + wrAddrQ.size(), 0);

    $display("[TB] Load 0x142, dirty miss with write-back stall");
    clearLogs();
    fork
      applyStimulus(32'h142, 1'b0, '0, rdata, lat);
      begin
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
          @(negedge Clk);
          if (MemReqVal && MemReqWrEn && MemAddr[1:0] == 2'd1) begin
            found = 1'b1;
            break;
          end
        end
        checkOutput("stallArmed", found, 1);
        MemReqRdy = 1'b0;
        repeat (5) @(negedge Clk);
        MemReqRdy = 1'b1;
      end
    join
    checkOutput("wbCount", wrAddrQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wbAddr", (i < wrAddrQ.size()) ? wrAddrQ[i] : 32'hFFFF_FFFF, 32'h40 + i);
      checkOutput("wbData", (i < wrDataQ.size()) ? wrDataQ[i] : 32'hFFFF_FFFF, expWb[i]);
    end
    checkOutput("wbFillCount", rdAddrQ.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("wbFillAddr", (i < rdAddrQ.size()) ? rdAddrQ[i] : 32'hFFFF_FFFF, 32'h140 + i);
    checkOutput("wbStallCycles", stallCycles, 5);
    checkOutput("wbRespData", rdata, 32'h1A2);
    checkOutput("wbLatency", lat, 20);

    $display("[TB] Reset during fill of 0x80");
    clearLogs();
    readDelay = 3;
    begin
      int acc;
      issueRequest(32'h80, 1'b0, '0, acc);
    end
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (MemReqVal && !MemReqWrEn && MemAddr == 32'h82) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    checkOutput("beat2Reached", found, 1);
    @(negedge Clk);
    resp0 = respCount;
    repl0 = replaceCount;
    Rst = 1'b1;
    #1;
    checkOutput("midRstCacheRst", CacheRst, 1);
    checkOutput("midRstMemReqVal", MemReqVal, 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    waitInit("midRst");
    checkOutput("midRstNoResp", respCount, resp0);
    checkOutput("midRstNoReplace", replaceCount, repl0);

    readDelay = 0;
    clearLogs();
    applyStimulus(32'h80, 1'b0, '0, rdata, lat);
    checkOutput("reMissReads", rdAddrQ.size(), 4);
    checkOutput("reMissLatency", lat, 11);
    checkOutput("reMissData", rdata, 32'hE0);
`ifdef CACHE_CTRL_PERF_EN
    checkOutput("perfHit", HitCnt, 0);
    checkOutput("perfMiss", MissCnt, 1);
    checkOutput("perfWb", WbCnt, 0);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
